pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Interlock and scheduling controller for the 16-bit pipelined MIPS datapath (IF, ID, EX).
- Tracks destination registers of in-flight instructions in a shift-register scoreboard.
- Stalls PC and IF/ID and injects an ID/EX bubble on RAW hazards.
- Flushes wrong-path instructions on taken branches.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- WB_DEPTH, 2: cycles after issue during which a result is not readable from the register file (scoreboard slots).
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  pipeline clock. All state updates on the falling edge, the same edge as the pipeline registers.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_op  in  4  IF/ID opcode (IR[15:12]).
- id_rs  in  2  IR[11:10].
- id_rt  in  2  IR[9:8].
- id_rd  in  2  IR[7:6].
- ex_branch_taken  in  1  branch in EX resolved taken.
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its value.
- ifid_flush  out  1  IF/ID loads 0 (nop).
- idex_bubble  out  1  ID/EX control bits forced to 0.
- fwd_a  out  2  forward select for A: 0 register file, 1 EX result, 2 previous EX result.
- fwd_b  out  2  forward select for B, same encoding as fwd_a.
- stall_cnt  out  CNT_W  saturating count of hazard stall cycles.

Behaviour:
- Instruction classes, decoded from id_op:
  - R-type 0000/0001/0010/0011/0111: reads rs and rt; writes rd.
  - 0100 addi: reads rs; writes rt.
  - 0101 lw: reads rs; writes rt; marked load.
  - 0110 sw: reads rs and rt; no write.
  - 1000/1001 beq/bne: reads rs and rt; no write.
  - Undefined opcodes: no reads, no writes.
- Register 0 never creates a hazard and is never recorded as a destination. All-zero nop therefore issues freely.
- Scoreboard: slots 0..WB_DEPTH-1, each holding {valid, reg[1:0], is_load}.
  - Every clock, slot i moves to slot i+1 and the last slot drops.
  - Slot 0 loads the issuing instruction's destination.
  - Slot 0 loads invalid when stalling, flushing, id_valid=0, or the instruction has no destination.
- hazard is combinational: any valid slot whose reg equals a source read by the ID instruction (id_valid=1).
- Stall, when hazard=1 and ex_branch_taken=0:
  - pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0.
  - stall_cnt increments; it saturates at all-ones.
- Taken branch, ex_branch_taken=1:
  - ifid_flush=1, idex_bubble=1, pc_hold=0, ifid_hold=0.
  - Overrides the stall; the cycle is not counted.
- Otherwise all control outputs are 0 and fwd_a/fwd_b are 0.
- Stall latency without forwarding, WB_DEPTH=2:
  - Consumer directly after producer: 2 stall cycles.
  - One instruction between: 1 stall cycle.
  - Two between: 0.
- Reset (async, any time, including mid-stall):
  - All slots invalid, stall_cnt=0.
  - Outputs recompute from cleared state, so pc_hold/ifid_hold/idex_bubble=0 unless ex_branch_taken=1.
- Outputs are combinational from scoreboard state and current inputs. No output depends on the same cycle's update.

Optional Feature:
Macro PIPELINE_HAZARD_FORWARD_EN.
- Defined:
  - A source matching a valid non-load slot 0 gets fwd=1 and does not stall.
  - A source matching a valid slot 1 gets fwd=2 and does not stall.
  - A source matching a load in slot 0 stalls 1 cycle, then forwards with fwd=2.
  - On multiple matches, the youngest slot wins.
  - Slots at index 2 and above always stall.
- Undefined: fwd_a and fwd_b are tied to 0 and every match stalls.

Decomposition:
- Package hazard_pkg holds:
  - Opcode constants: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE.
  - The scoreboard slot typedef {valid, reg, is_load}.
  - The fwd select encodings FWD_RF, FWD_EX, FWD_EX2.
- One combinational sub-module, instr_class_decode: id_op in; uses_rs, uses_rt, writes, dst_is_rd, is_load out.
- Scoreboard, counter and output logic stay in pipeline_hazard_ctrl.

Test Plan:
1. Reset, then nop stream → all control outputs 0, stall_cnt=0, slots stay invalid.
2. addi $1,$0,15 followed immediately by and $3,$1,$2, macro off → pc_hold=ifid_hold=idex_bubble=1 for exactly 2 cycles; stall_cnt=2; and issues on cycle 3.
3. Same pair with one nop between → 1 stall cycle. With two nops between → 0 stalls.
4. Stall active when ex_branch_taken=1 → ifid_flush=1, idex_bubble=1, pc_hold=0; stall_cnt unchanged.
5. Macro on:
   - sub $2,$1,$3 then or $2,$2,$3 → 0 stalls, fwd_a=1.
   - lw $1 then add using $1 → 1 stall, then fwd_a=2.
6. Force stall_cnt to 16'hFFFE, apply 3 stall cycles → 16'hFFFF held. Assert rst_n=0 mid-stall → stall_cnt=0, pc_hold=0 without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the IF/ID/EX hazard controller: opcodes, scoreboard slot, forward selects.
// Forwarding is enabled by defining PIPELINE_HAZARD_FORWARD_EN.
package hazard_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_LW   = 4'b0101;
    localparam logic [3:0] OP_SW   = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_BNE  = 4'b1001;

    typedef struct packed {
        logic       valid;
        logic [1:0] reg_id;
        logic       is_load;
    } sb_slot_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_EX2 = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/instr_class_decode.sv
// Classifies the ID-stage opcode into register reads, register write and load-ness.
module instr_class_decode
    import hazard_pkg::*;
(
    input  logic [3:0] id_op,
    output logic       uses_rs,
    output logic       uses_rt,
    output logic       writes,
    output logic       dst_is_rd,
    output logic       is_load
);

    always_comb begin
        uses_rs   = 1'b0;
        uses_rt   = 1'b0;
        writes    = 1'b0;
        dst_is_rd = 1'b0;
        is_load   = 1'b0;
        case (id_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
                uses_rs   = 1'b1;
                uses_rt   = 1'b1;
                writes    = 1'b1;
                dst_is_rd = 1'b1;
            end
            OP_ADDI: begin
                uses_rs = 1'b1;
                writes  = 1'b1;
            end
            OP_LW: begin
                uses_rs = 1'b1;
                writes  = 1'b1;
                is_load = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW interlock, branch flush and stall counter for the 3-stage MIPS pipeline.
// Define PIPELINE_HAZARD_FORWARD_EN to resolve young hazards by forwarding instead of stalling.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int WB_DEPTH = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_op,
    input  logic [1:0]       id_rs,
    input  logic [1:0]       id_rt,
    input  logic [1:0]       id_rd,
    input  logic             ex_branch_taken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

`ifdef PIPELINE_HAZARD_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    sb_slot_t [WB_DEPTH-1:0] sb;
    sb_slot_t                new_slot;

    logic       uses_rs, uses_rt, writes, dst_is_rd, is_load;
    logic [1:0] dst;
    logic [2:0] res_a, res_b;
    logic       hazard, stall;

    instr_class_decode u_decode (
        .id_op     (id_op),
        .uses_rs   (uses_rs),
        .uses_rt   (uses_rt),
        .writes    (writes),
        .dst_is_rd (dst_is_rd),
        .is_load   (is_load)
    );

    // Returns {stall, fwd_sel}; scanning oldest to youngest lets the youngest match win.
    function automatic logic [2:0] resolve(input logic need, input logic [1:0] src,
                                           input sb_slot_t [WB_DEPTH-1:0] slots);
        logic     stl;
        fwd_sel_t sel;
        stl = 1'b0;
        sel = FWD_RF;
        if (need) begin
            for (int i = WB_DEPTH - 1; i >= 0; i--) begin
                if (slots[i].valid && slots[i].reg_id == src) begin
                    if (FWD_EN && i == 0 && !slots[i].is_load) begin
                        stl = 1'b0;
                        sel = FWD_EX;
                    end else if (FWD_EN && i == 1) begin
                        stl = 1'b0;
                        sel = FWD_EX2;
                    end else begin
                        stl = 1'b1;
                        sel = FWD_RF;
                    end
                end
            end
        end
        return {stl, sel};
    endfunction

    always_comb begin
        res_a  = resolve(id_valid && uses_rs && (id_rs != 2'd0), id_rs, sb);
        res_b  = resolve(id_valid && uses_rt && (id_rt != 2'd0), id_rt, sb);
        hazard = res_a[2] | res_b[2];
        stall  = hazard & ~ex_branch_taken;
    end

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
        if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (hazard) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            fwd_a = res_a[1:0];
            fwd_b = res_b[1:0];
        end
    end

    // Only an instruction that actually leaves ID with a non-zero destination is tracked.
    always_comb begin
        dst      = dst_is_rd ? id_rd : id_rt;
        new_slot = '0;
        if (id_valid && writes && !hazard && !ex_branch_taken && dst != 2'd0) begin
            new_slot.valid   = 1'b1;
            new_slot.reg_id  = dst;
            new_slot.is_load = is_load;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb        <= '0;
            stall_cnt <= '0;
        end else begin
            sb[0] <= new_slot;
            for (int i = 1; i < WB_DEPTH; i++) begin
                sb[i] <= sb[i-1];
            end
            if (stall && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random traffic against an issue-history model.
// Follows PIPELINE_HAZARD_FORWARD_EN in the model so it serves both builds.
module tb_pipeline_hazard_ctrl;

    localparam int WB_DEPTH = 2;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef PIPELINE_HAZARD_FORWARD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             id_valid;
    logic [3:0]       id_op;
    logic [1:0]       id_rs, id_rt, id_rd;
    logic             ex_branch_taken;
    logic             pc_hold, ifid_hold, ifid_flush, idex_bubble;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    pipeline_hazard_ctrl #(.WB_DEPTH(WB_DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_op           (id_op),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .ex_branch_taken (ex_branch_taken),
        .pc_hold         (pc_hold),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    // hist[k] is what left ID k+1 cycles ago; dst 0 means nothing was written
    typedef struct {
        int dst;
        bit ld;
    } issued_t;

    issued_t hist[$];
    int      exp_cnt;
    int      checks = 0;
    int      errors = 0;
    bit      e_hold, e_flush, e_bubble, e_stall, last_stall;
    int      e_fwd_a, e_fwd_b;
    issued_t e_issue;

    function automatic void classify(input logic [3:0] op, output bit ra, output bit rb,
                                     output bit w, output bit dst_rd, output bit ld);
        ra = 0; rb = 0; w = 0; dst_rd = 0; ld = 0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd7: begin ra = 1; rb = 1; w = 1; dst_rd = 1; end
            4'd4:       begin ra = 1; w = 1; end
            4'd5:       begin ra = 1; w = 1; ld = 1; end
            4'd6, 4'd8, 4'd9: begin ra = 1; rb = 1; end
            default: ;
        endcase
    endfunction

    function automatic void resolve(input bit need, input int src, output bit stl, output int fwd);
        stl = 0;
        fwd = 0;
        if (!need) return;
        for (int age = 0; age < hist.size(); age++) begin
            if (hist[age].dst == src) begin
                if (FWD_ON && age == 0 && !hist[age].ld) fwd = 1;
                else if (FWD_ON && age == 1)             fwd = 2;
                else                                      stl = 1;
                return;
            end
        end
    endfunction

    task automatic modelReset();
        issued_t none;
        none.dst = 0;
        none.ld  = 0;
        hist.delete();
        repeat (WB_DEPTH) hist.push_back(none);
        exp_cnt = 0;
    endtask

    task automatic checkSig(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit ra, rb, w, dst_rd, ld, sa, sb, hz;
        int fa, fb;
        classify(id_op, ra, rb, w, dst_rd, ld);
        resolve(id_valid && ra && id_rs != 0, int'(id_rs), sa, fa);
        resolve(id_valid && rb && id_rt != 0, int'(id_rt), sb, fb);
        hz = sa || sb;
        e_hold = 0; e_flush = 0; e_bubble = 0; e_stall = 0; e_fwd_a = 0; e_fwd_b = 0;
        if (ex_branch_taken) begin
            e_flush = 1; e_bubble = 1;
        end else if (hz) begin
            e_hold = 1; e_bubble = 1; e_stall = 1;
        end else begin
            e_fwd_a = fa; e_fwd_b = fb;
        end
        e_issue.dst = 0;
        e_issue.ld  = 0;
        if (id_valid && !ex_branch_taken && !hz && w) begin
            e_issue.dst = dst_rd ? int'(id_rd) : int'(id_rt);
            e_issue.ld  = (e_issue.dst != 0) && ld;
        end
        checkSig("pc_hold",     32'(pc_hold),     32'(e_hold));
        checkSig("ifid_hold",   32'(ifid_hold),   32'(e_hold));
        checkSig("ifid_flush",  32'(ifid_flush),  32'(e_flush));
        checkSig("idex_bubble", 32'(idex_bubble), 32'(e_bubble));
        checkSig("fwd_a",       32'(fwd_a),       32'(e_fwd_a));
        checkSig("fwd_b",       32'(fwd_b),       32'(e_fwd_b));
        checkSig("stall_cnt",   32'(stall_cnt),   32'(exp_cnt));
    endtask

    task automatic applyStimulus(input bit v, input logic [3:0] op, input logic [1:0] rs,
                                 input logic [1:0] rt, input logic [1:0] rd, input bit br);
        @(posedge clk);
        id_valid = v; id_op = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = br;
        #2;
        checkOutput();
        @(negedge clk);
        #1;
        if (e_stall && exp_cnt < CNT_MAX) exp_cnt++;
        hist.push_front(e_issue);
        if (hist.size() > WB_DEPTH) void'(hist.pop_back());
        last_stall = e_stall;
    endtask

    // Holds the instruction in ID until it leaves, with a bounded wait
    task automatic issueInstr(input logic [3:0] op, input logic [1:0] rs,
                              input logic [1:0] rt, input logic [1:0] rd);
        int n = 0;
        do begin
            applyStimulus(1'b1, op, rs, rt, rd, 1'b0);
            n++;
        end while (last_stall && n < 6);
        checks++;
        assert (last_stall === 1'b0) else begin
            errors++;
            $error("FAIL issue_timeout: observed stalled after %0d cycles expected issue", n);
        end
    endtask

    task automatic nop();
        applyStimulus(1'b1, 4'b0000, 2'd0, 2'd0, 2'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_op = 0; id_rs = 0; id_rt = 0; id_rd = 0; ex_branch_taken = 0;
        last_stall = 0;
        modelReset();
        #7;
        checkOutput();
        @(posedge clk);
        rst_n = 1'b1;

        repeat (4) nop();

        // addi $1,$0,15 then and $3,$1,$2, back to back
        issueInstr(4'b0100, 2'd0, 2'd1, 2'd0);
        issueInstr(4'b0010, 2'd1, 2'd2, 2'd3);
        repeat (2) nop();

        // one and two nops between producer and consumer
        issueInstr(4'b0100, 2'd0, 2'd1, 2'd0);
        nop();
        issueInstr(4'b0010, 2'd1, 2'd2, 2'd3);
        repeat (2) nop();
        issueInstr(4'b0100, 2'd0, 2'd1, 2'd0);
        repeat (2) nop();
        issueInstr(4'b0010, 2'd1, 2'd2, 2'd3);
        repeat (2) nop();

        // taken branch overrides a pending stall
        issueInstr(4'b0100, 2'd0, 2'd1, 2'd0);
        applyStimulus(1'b1, 4'b0010, 2'd1, 2'd2, 2'd3, 1'b1);
        repeat (2) nop();

        // sub $2,$1,$3 ; or $2,$2,$3 ; lw $1 ; add $3,$1,$1
        issueInstr(4'b0001, 2'd1, 2'd3, 2'd2);
        issueInstr(4'b0011, 2'd2, 2'd3, 2'd2);
        issueInstr(4'b0101, 2'd0, 2'd1, 2'd0);
        issueInstr(4'b0000, 2'd1, 2'd1, 2'd3);
        repeat (2) nop();

        // enough load-use stalls to saturate the narrow counter
        repeat (20) begin
            issueInstr(4'b0101, 2'd0, 2'd1, 2'd0);
            issueInstr(4'b0000, 2'd1, 2'd2, 2'd3);
        end
        repeat (2) nop();

        // asynchronous reset in the middle of a load-use stall
        issueInstr(4'b0101, 2'd0, 2'd1, 2'd0);
        @(posedge clk);
        id_valid = 1; id_op = 4'b0000; id_rs = 2'd1; id_rt = 2'd2; id_rd = 2'd3; ex_branch_taken = 0;
        #2;
        checkOutput();
        #1;
        rst_n = 1'b0;
        #1;
        checkSig("rst_pc_hold",     32'(pc_hold),     32'd0);
        checkSig("rst_ifid_hold",   32'(ifid_hold),   32'd0);
        checkSig("rst_idex_bubble", 32'(idex_bubble), 32'd0);
        checkSig("rst_stall_cnt",   32'(stall_cnt),   32'd0);
        modelReset();
        checkOutput();
        id_valid = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) nop();

        // random traffic
        repeat (400) begin
            applyStimulus(($urandom % 8) != 0, 4'($urandom_range(0, 10)), 2'($urandom),
                          2'($urandom), 2'($urandom), ($urandom % 12) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no completion expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
